// File: rtl/sigmoid_pipe.sv
// Logistic activation a = sigmoid(z) using the PLAN piecewise-linear approximation.
// The datapath uses only shifts and adds, and the pipeline stalls as a whole under output backpressure.
module sigmoid_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] a
);

  typedef enum logic [1:0] {
    region_0,
    region_1,
    region_2,
    region_3
  } region_t;

  localparam logic [WIDTH:0] one_val   = (WIDTH+1)'(1)  << FRAC;
  localparam logic [WIDTH:0] half_val  = (WIDTH+1)'(1)  << (FRAC - 1);
  localparam logic [WIDTH:0] th_5      = (WIDTH+1)'(5)  << FRAC;
  localparam logic [WIDTH:0] th_2375   = (WIDTH+1)'(19) << (FRAC - 3);
  localparam logic [WIDTH:0] c_0625    = (WIDTH+1)'(5)  << (FRAC - 3);
  localparam logic [WIDTH:0] c_084375  = (WIDTH+1)'(27) << (FRAC - 5);
  localparam logic [WIDTH:0] most_neg  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] max_pos   = {1'b0, {WIDTH{1'b1}}};

  // Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
  // Every stage moves together when adv = !out_valid | out_ready and holds otherwise,
  // so in_ready depends combinationally on out_ready only.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Capture register: z is taken here on the accepting edge.
  logic           v0;
  logic [WIDTH:0] z0;

  // S1: sign, magnitude and region.
  logic           v1;
  logic           neg1;
  logic [WIDTH:0] m1;
  region_t        region1;

  // S2: positive-side curve value.
  logic           v2;
  logic           neg2;
  logic [WIDTH:0] y2;

  logic           neg_c;
  logic [WIDTH:0] m_c;
  region_t        region_c;
  logic [WIDTH:0] y_c;
  logic [WIDTH:0] a_c;

  always_comb begin
    neg_c = z0[WIDTH];
    m_c   = z0;
    if (neg_c) begin
      // The most-negative value has no positive counterpart, so it saturates.
      if (z0 == most_neg) m_c = max_pos;
      else                m_c = -z0;
    end
    if (m_c >= th_5)         region_c = region_3;
    else if (m_c >= th_2375) region_c = region_2;
    else if (m_c >= one_val) region_c = region_1;
    else                     region_c = region_0;
  end

  always_comb begin
    y_c = half_val;
    case (region1)
      region_3: y_c = one_val;
      region_2: y_c = (m1 >> 5) + c_084375;
      region_1: y_c = (m1 >> 3) + c_0625;
      default:  y_c = (m1 >> 2) + half_val;
    endcase
  end

  // y never exceeds 1.0, so the mirror for negative inputs cannot go below zero.
  always_comb begin
    a_c = neg2 ? (one_val - y2) : y2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      z0        <= '0;
      v1        <= 1'b0;
      neg1      <= 1'b0;
      m1        <= '0;
      region1   <= region_0;
      v2        <= 1'b0;
      neg2      <= 1'b0;
      y2        <= '0;
      out_valid <= 1'b0;
      a         <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) z0 <= z;
      v1 <= v0;
      if (v0) begin
        neg1    <= neg_c;
        m1      <= m_c;
        region1 <= region_c;
      end
      v2 <= v1;
      if (v1) begin
        neg2 <= neg1;
        y2   <= y_c;
      end
      out_valid <= v2;
      if (v2) a <= a_c;
    end
  end

endmodule
